// File: rtl/alu.sv
// Opcode package and registered integer ALU: add/sub with carry, bitwise logic, shifts.
// Result and carry/overflow/negative/zero flags update together, one cycle after the inputs.
package alu_ops;
    typedef enum logic [3:0] {
        ADD_OP      = 4'd0,
        SUB_OP      = 4'd1,
        AND_OP      = 4'd2,
        OR_OP       = 4'd3,
        XOR_OP      = 4'd4,
        NOT_OP      = 4'd5,
        LL_SHIFT_OP = 4'd6,
        LR_SHIFT_OP = 4'd7,
        AL_SHIFT_OP = 4'd8,
        AR_SHIFT_OP = 4'd9
    } op_t;
endpackage

module alu
    import alu_ops::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int MSB = WIDTH - 1;

    logic        [WIDTH:0]   sum_ext;
    logic        [WIDTH:0]   diff_ext;
    logic signed [WIDTH-1:0] a_s;
    logic        [WIDTH-1:0] y_p0;
    logic                    cout_p0;
    logic                    ovf_p0;

    assign sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign a_s      = signed'(a);

    // Stage p0: combinational next-state result and flags.
    // Shifts by b >= WIDTH need no clamp: SV shifts yield zero fill, and >>> on a
    // signed operand yields full sign fill, exactly the required saturation.
    always_comb begin
        y_p0    = '0;
        cout_p0 = 1'b0;
        ovf_p0  = 1'b0;
        case (opcode)
            ADD_OP: begin
                y_p0    = sum_ext[WIDTH-1:0];
                cout_p0 = sum_ext[WIDTH];
                ovf_p0  = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
            end
            SUB_OP: begin
                y_p0    = diff_ext[WIDTH-1:0];
                cout_p0 = diff_ext[WIDTH];
                ovf_p0  = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
            end
            AND_OP:      y_p0 = a & b;
            OR_OP:       y_p0 = a | b;
            XOR_OP:      y_p0 = a ^ b;
            NOT_OP:      y_p0 = ~a;
            LL_SHIFT_OP: y_p0 = a << b;
            AL_SHIFT_OP: y_p0 = a << b;
            LR_SHIFT_OP: y_p0 = a >> b;
            AR_SHIFT_OP: y_p0 = unsigned'(a_s >>> b);
            default:     y_p0 = '0;
        endcase
    end

    // Stage p1: output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b1;
        end else begin
            y        <= y_p0;
            cout     <= cout_p0;
            overflow <= ovf_p0;
            negative <= y_p0[MSB];
            zero     <= (y_p0 == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit alu: reset, arithmetic, logic, shifts,
// reserved opcodes, back-to-back latency and mid-stream asynchronous reset.
module tb_alu;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       opcode = 4'd0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             overflow;
    logic             negative;
    logic             zero;

    int n_pass = 0;
    int n_total = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b), .cin(cin),
        .y(y), .cout(cout), .overflow(overflow), .negative(negative), .zero(zero)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ey, input logic ec,
                           input logic ev, input logic en, input logic ez);
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ev));
        chk({tag, ".neg"}, 32'(negative), 32'(en));
        chk({tag, ".zero"}, 32'(zero), 32'(ez));
    endtask

    // Drive at negedge, let one rising edge pass, sample 1 time unit after it.
    task automatic run(input string tag, input logic [3:0] op, input logic [3:0] ia,
                       input logic [3:0] ib, input logic ic, input logic [3:0] ey,
                       input logic ec, input logic ev, input logic en, input logic ez);
        @(negedge clk);
        opcode = op; a = ia; b = ib; cin = ic;
        @(posedge clk);
        #1;
        chk_out(tag, ey, ec, ev, en, ez);
    endtask

    initial begin
        // Asynchronous reset with the clock stopped.
        #3 rst = 1'b1;
        #2;
        chk_out("rst_noclk", 4'b0000, 0, 0, 0, 1);
        opcode = 4'd0; a = 4'b0000; b = 4'b0000; cin = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_out("rst_hold", 4'b0000, 0, 0, 0, 1);
        clk_en = 1'b1;
        run("add_cin", 4'd0, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 0, 0);

        run("add_a", 4'd0, 4'b0101, 4'b0001, 0, 4'b0110, 0, 0, 0, 0);
        run("add_ovf", 4'd0, 4'b0111, 4'b0001, 0, 4'b1000, 0, 1, 1, 0);
        run("add_cout", 4'd0, 4'b1111, 4'b0001, 0, 4'b0000, 1, 0, 0, 1);

        run("sub_ovf", 4'd1, 4'b1000, 4'b0011, 1, 4'b0100, 0, 1, 0, 0);
        run("sub_b", 4'd1, 4'b1111, 4'b1000, 1, 4'b0110, 0, 0, 0, 0);
        run("sub_borrow", 4'd1, 4'b0001, 4'b0011, 0, 4'b1110, 1, 0, 1, 0);

        run("and", 4'd2, 4'b1010, 4'b0111, 1, 4'b0010, 0, 0, 0, 0);
        run("or", 4'd3, 4'b1000, 4'b0100, 1, 4'b1100, 0, 0, 1, 0);
        run("xor", 4'd4, 4'b1010, 4'b1010, 0, 4'b0000, 0, 0, 0, 1);
        run("not", 4'd5, 4'b1000, 4'b1111, 1, 4'b0111, 0, 0, 0, 0);

        run("ll3", 4'd6, 4'b0001, 4'd3, 1, 4'b1000, 0, 0, 1, 0);
        run("ll_out", 4'd6, 4'b1000, 4'd1, 0, 4'b0000, 0, 0, 0, 1);
        run("ll0", 4'd6, 4'b1011, 4'd0, 0, 4'b1011, 0, 0, 1, 0);
        run("lr1", 4'd7, 4'b1011, 4'd1, 0, 4'b0101, 0, 0, 0, 0);
        run("al1", 4'd8, 4'b0101, 4'd1, 0, 4'b1010, 0, 0, 1, 0);
        run("ar_neg", 4'd9, 4'b1001, 4'd1, 0, 4'b1100, 0, 0, 1, 0);
        run("ar_ones", 4'd9, 4'b1110, 4'd1, 0, 4'b1111, 0, 0, 1, 0);
        run("ar_pos", 4'd9, 4'b0011, 4'd1, 1, 4'b0001, 0, 0, 0, 0);
        run("ar_big", 4'd9, 4'b1000, 4'd5, 0, 4'b1111, 0, 0, 1, 0);
        run("ar_big_pos", 4'd9, 4'b0111, 4'd4, 0, 4'b0000, 0, 0, 0, 1);
        run("lr_big", 4'd7, 4'b1000, 4'd4, 0, 4'b0000, 0, 0, 0, 1);
        run("ar0", 4'd9, 4'b1010, 4'd0, 0, 4'b1010, 0, 0, 1, 0);

        run("rsv15", 4'd15, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 1);
        run("rsv10", 4'd10, 4'b0101, 4'b0011, 1, 4'b0000, 0, 0, 0, 1);

        // Back-to-back: inputs change at negedge, output must still show the
        // previous result until the following rising edge.
        run("b2b_1", 4'd0, 4'b0010, 4'b0011, 0, 4'b0101, 0, 0, 0, 0);
        @(negedge clk);
        opcode = 4'd1; a = 4'b0000; b = 4'b0001; cin = 1'b0;
        #1;
        chk("b2b_hold.y", 32'(y), 32'(4'b0101));
        @(posedge clk);
        #1;
        chk_out("b2b_2", 4'b1111, 1, 0, 1, 0);
        run("b2b_3", 4'd5, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 1);

        // Mid-stream asynchronous reset between edges.
        run("pre_rst", 4'd0, 4'b0111, 4'b0001, 0, 4'b1000, 0, 1, 1, 0);
        @(negedge clk);
        opcode = 4'd3; a = 4'b0011; b = 4'b0100; cin = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("rst_mid", 4'b0000, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        chk_out("rst_held", 4'b0000, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_rst", 4'b0111, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised, registered integer ALU for the datapath. Implements add/subtract with carry-in, bitwise logic, and logical/arithmetic shifts.
- Inputs are sampled on each rising clock edge. The result and four status flags (carry, overflow, negative, zero) are presented from output registers.
- Opcodes come from the shared package alu_ops.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  operation select (alu_ops encoding)
- a  input  WIDTH  operand A; the shifted value for shift ops
- b  input  WIDTH  operand B; unsigned shift amount for shift ops
- cin  input  1  carry-in (ADD) / borrow-in (SUB)
- y  output  WIDTH  registered result
- cout  output  1  registered carry-out (ADD) / borrow-out (SUB)
- overflow  output  1  registered signed (two's complement) overflow
- negative  output  1  registered y[WIDTH-1]
- zero  output  1  registered (y == 0)

Behaviour:
- Package alu_ops encoding, 4-bit: ADD_OP=0, SUB_OP=1, AND_OP=2, OR_OP=3, XOR_OP=4, NOT_OP=5, LL_SHIFT_OP=6, LR_SHIFT_OP=7, AL_SHIFT_OP=8, AR_SHIFT_OP=9. Codes 10–15 are reserved.
- Reset (rst=1, asynchronous, no clock needed): y=0, cout=0, overflow=0, negative=0, zero=1. Outputs hold these values while rst is high.
- Latency: one cycle. The result of inputs present at rising edge N is visible after edge N and held until the next edge. There is no handshake; a new operation is accepted every cycle.
- The next-state result is computed combinationally from opcode/a/b/cin and registered together with all flags on the same edge.
- ADD: {cout,y} = a + b + cin (WIDTH+1-bit sum). overflow = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
- SUB: y = (a - b - cin) mod 2^WIDTH.
  - cout = 1 iff a < b + cin, unsigned (borrow out).
  - overflow = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
- AND/OR/XOR: bitwise a op b. NOT: y = ~a; b and cin are ignored.
- LL_SHIFT and AL_SHIFT (identical): y = a << b, zero fill. If b ≥ WIDTH, y = 0.
- LR_SHIFT: y = a >> b, zero fill. If b ≥ WIDTH, y = 0.
- AR_SHIFT: y = a >>> b, sign fill from a[MSB]. If b ≥ WIDTH, every bit of y = a[MSB].
- Shift amount b = 0 gives y = a for all shift ops.
- cin is ignored for all ops except ADD and SUB.
- cout and overflow are 0 for all ops except ADD and SUB.
- negative = y[MSB] and zero = (y==0) for every op, computed from the registered result.
- Reserved opcodes: y=0, cout=0, overflow=0, negative=0, zero=1.
- Reset asserted mid-stream: outputs go to reset values immediately. The first edge after deassertion registers the then-current inputs.
- Purely synchronous datapath apart from the reset; no internal state beyond the output registers.

Test Plan:
- Reset: assert rst with no clock → y=0000, cout=0, overflow=0, negative=0, zero=1. Release rst, clock ADD a=0000 b=0000 cin=1 → y=0001, zero=0.
- ADD (WIDTH=4):
  - 0101+0001, cin 0 → y=0110, cout 0.
  - 0111+0001 → y=1000, overflow 1, negative 1.
  - 1111+0001 → y=0000, cout 1, zero 1.
- SUB:
  - 1000−0011, cin 1 → y=0100, cout 0, overflow 1.
  - 1111−1000, cin 1 → y=0110, cout 0.
  - 0001−0011 → y=1110, cout 1, negative 1.
- Logic:
  - AND 1010&0111 → 0010.
  - OR 1000|0100 → 1100.
  - XOR 1010^1010 → 0000, zero 1.
  - NOT 1000 → 0111.
- Shifts:
  - LL 0001 by 3 → 1000; LL 1000 by 1 → 0000.
  - LR 1011 by 1 → 0101.
  - AL 0101 by 1 → 1010.
  - AR 1001 by 1 → 1100; AR 1110 by 1 → 1111; AR 0011 by 1 → 0001.
  - AR 1000 by 5 → 1111; LR 1000 by 4 → 0000.
- Back-to-back ops on consecutive edges: each result appears exactly one cycle after its inputs. Reserved opcode 1111 → y=0, zero=1.
